mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Game-round controller and mole-slot scheduler for the whack-a-mole datapath.
- Sits between the spawn timer (mole_control_fsm/rng_mole) and the debounced switches, LEDs, score_counter and display.
- Runs the round timer, places moles on LEDs from random indices, enforces a level-dependent lifetime per mole, and converts switch rising edges into hit, miss and wrong-press events.

Parameters:
- NUM_LEDS, 18: number of mole positions (LEDR/SW width).
- MAX_ACTIVE, 4: maximum simultaneous moles (slot-table depth).
- TICK_CYCLES, 50000: clk cycles per 1 ms tick (50 MHz).
- GAME_MS, 30000: round length in ms.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; start or restart a round.
- level  in  2  difficulty, 0 (easy) to 3 (hard).
- spawn_req  in  1  one-cycle pulse requesting a new mole.
- rand_idx  in  5  random LED index for spawn_req.
- sw_pressed  in  NUM_LEDS  debounced switch levels.
- led_mask  out  NUM_LEDS  lit moles.
- hit_count  out  $clog2(MAX_ACTIVE+1)  moles hit this cycle.
- miss_count  out  $clog2(MAX_ACTIVE+1)  moles expired this cycle.
- wrong_press  out  1  rising edge on an unlit position.
- game_active  out  1  high in PLAYING.
- game_over  out  1  high in GAME_OVER.
- time_left_ms  out  15  remaining round time.

Behaviour:
- Reset values (async, reset_n low):
  - FSM state = IDLE; all slots invalid.
  - led_mask = 0, hit_count = 0, miss_count = 0, wrong_press = 0.
  - game_active = 0, game_over = 0, time_left_ms = 0.
  - Prescaler = 0; sw_prev = 0.
- All outputs are registered. Every event is visible one cycle after the causing input.
- Tick:
  - Prescaler counts 0 to TICK_CYCLES-1. tick is asserted on wrap.
  - Prescaler clears on start.
- FSM states: IDLE, PLAYING, GAME_OVER.
  - start in any state -> PLAYING. Clears all slots and the prescaler; time_left_ms = GAME_MS.
  - PLAYING: on each tick, time_left_ms decrements by 1.
  - PLAYING with tick and time_left_ms == 1 -> GAME_OVER. time_left_ms = 0; all slots cleared silently (no misses counted).
  - GAME_OVER holds until start.
  - IDLE and GAME_OVER: spawn_req and switches are ignored; all count outputs stay 0.
- Slot table: MAX_ACTIVE entries, each holding {valid, idx[4:0], life[10:0]}.
  - led_mask is the OR of the valid slots' one-hot idx.
- Spawn (PLAYING and spawn_req), accepted only if all of the following hold:
  - rand_idx < NUM_LEDS;
  - led_mask[rand_idx] == 0 (registered value);
  - a free slot exists.
  - On accept: the lowest-numbered free slot is loaded with idx = rand_idx and life = LIFE_MS[level].
  - Otherwise the request is dropped. There is no queue or retry.
- Lifetime: on tick, each valid slot's life decrements. A slot at life == 1 on tick is invalidated and counts as a miss.
- Hit detection:
  - edge[i] = sw_pressed[i] & ~sw_prev[i]; sw_prev updates every cycle in every state.
  - edge[i] with led_mask[i] set: that slot is invalidated and counts as a hit.
  - edge[i] with led_mask[i] clear: wrong_press = 1 for one cycle (asserted once even if several edges occur).
  - Multiple hits in one cycle are all counted in hit_count.
- Simultaneous events:
  - Hit and expiry on the same slot in the same cycle: counted as a hit only.
  - A slot freed this cycle is not allocatable until the next cycle.
  - A spawn onto an index being hit this cycle is rejected.
  - start together with tick, spawn or edge: start wins; no counts that cycle.
  - GAME_OVER entry together with a hit: the hit is counted; misses are suppressed.
- Level:
  - Sampled only at spawn. Changing level mid-round does not alter live slots.
  - LIFE_MS = {1500, 1000, 700, 450} ms for levels 0..3.
- Mid-round reset_n: everything returns to reset values. No counts are emitted.

Decomposition:
- Package whack_pkg holds:
  - game_state_t enum {IDLE, PLAYING, GAME_OVER};
  - mole_slot_t packed struct;
  - LIFE_MS constant array;
  - NUM_LEDS_DEFAULT.
- One sub-module: ms_tick_gen (prescaler, clk/reset_n/clear in, tick out).
- Slot allocation and edge logic stay in mole_scheduler.

Test Plan:
Bench uses TICK_CYCLES=10 and GAME_MS=100.
1. Reset, then start -> game_active=1, time_left_ms=100. After 1000 cycles: time_left_ms=0, game_over=1, led_mask=0, miss_count never nonzero on that cycle.
2. level=0, spawn_req with rand_idx=5 -> led_mask=18'h00020 next cycle. With no press, miss_count=1 exactly after 1500 ticks and led_mask=0. Note: GAME_MS must be set to 2000 for this case.
3. Fill slots with idx 0, 1, 2, 3, then spawn idx 4 -> rejected, led_mask=18'h0000F. Also: spawn idx 2 again -> rejected; rand_idx=20 -> rejected.
4. Moles at 3 and 7; raise sw_pressed[3] and sw_pressed[7] in the same cycle -> hit_count=2, led_mask=0. Raise sw_pressed[9] -> wrong_press=1 for one cycle. Holding the switch high produces no further events.
5. Mole at idx 6 with life=1. Rising edge on sw_pressed[6] coincides with tick -> hit_count=1, miss_count=0.
6. Mid-round with 2 moles live: pulse start -> led_mask=0, counts 0, time_left_ms=100. Then assert reset_n=0 asynchronously -> all outputs 0 immediately.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole datapath.
//   game_state_t : round controller states
//   mole_slot_t  : one entry of the live-mole table {valid, idx, life}
//   LIFE_MS      : mole lifetime in ms, indexed by difficulty level 0..3
package whack_pkg;

  localparam int NUM_LEDS_DEFAULT = 18;
  localparam int IDX_W            = 5;
  localparam int LIFE_W           = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [LIFE_W-1:0] life;
  } mole_slot_t;

  localparam logic [LIFE_W-1:0] LIFE_MS [4] = '{11'd1500, 11'd1000, 11'd700, 11'd450};

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restarts the count from zero (round start)
//   tick         : high for the one cycle in which the count wraps
module ms_tick_gen #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(TICK_CYCLES - 1));
  assign tick = wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Round controller and mole-slot scheduler.
//   start        : pulse, (re)starts a round from any state
//   level        : difficulty 0..3, sampled when a mole is spawned
//   spawn_req    : pulse with rand_idx, asks for a mole at that LED
//   sw_pressed   : debounced switch levels; rising edges are hits/wrong presses
//   led_mask     : lit moles
//   hit_count    : moles hit this cycle
//   miss_count   : moles that expired this cycle
//   wrong_press  : a rising edge landed on an unlit position
//   game_active / game_over / time_left_ms : round status
//   state_dbg    : current controller state
// Handshake: start and spawn_req are single-cycle pulses with no ready.
// A spawn_req is consumed in the cycle it is high: it is either accepted
// or silently dropped, never held or retried. All outputs are registered,
// so every event appears one cycle after its cause.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int  NUM_LEDS    = NUM_LEDS_DEFAULT,
  parameter int  MAX_ACTIVE  = 4,
  parameter int  TICK_CYCLES = 50000,
  parameter int  GAME_MS     = 30000,
  localparam int CNT_W       = $clog2(MAX_ACTIVE + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          level,
  input  logic                spawn_req,
  input  logic [IDX_W-1:0]    rand_idx,
  input  logic [NUM_LEDS-1:0] sw_pressed,
  output logic [NUM_LEDS-1:0] led_mask,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic                wrong_press,
  output logic                game_active,
  output logic                game_over,
  output logic [14:0]         time_left_ms,
  output game_state_t         state_dbg
);

  logic                        tick;
  game_state_t                 state_q, state_d;
  mole_slot_t [MAX_ACTIVE-1:0] slots_q, slots_d;
  logic [NUM_LEDS-1:0]         sw_prev_q, edges, led_d;
  logic [14:0]                 time_d;
  logic [CNT_W-1:0]            hit_d, miss_d;
  logic                        wrong_d, game_end, spawn_ok, placed;

  ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start),
    .tick    (tick)
  );

  // Out-of-range indices decode to all zeros, so they never match a switch
  // and never look occupied.
  function automatic logic [NUM_LEDS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int b = 0; b < NUM_LEDS; b++) begin
      if (int'(idx) == b) onehot[b] = 1'b1;
    end
  endfunction

  assign edges     = sw_pressed & ~sw_prev_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    slots_d  = slots_q;
    time_d   = time_left_ms;
    hit_d    = '0;
    miss_d   = '0;
    wrong_d  = 1'b0;
    game_end = 1'b0;
    spawn_ok = 1'b0;
    placed   = 1'b0;
    led_d    = '0;

    if (start) begin
      // start overrides any coincident tick, spawn or switch edge.
      state_d = PLAYING;
      slots_d = '0;
      time_d  = 15'(GAME_MS);
    end else if (state_q == PLAYING) begin
      game_end = tick && (time_left_ms == 15'd1);
      wrong_d  = |(edges & ~led_mask);

      // A hit takes precedence over an expiry of the same slot.
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        if (slots_q[i].valid) begin
          if (|(edges & onehot(slots_q[i].idx))) begin
            slots_d[i].valid = 1'b0;
            hit_d            = hit_d + CNT_W'(1);
          end else if (tick) begin
            if (slots_q[i].life == 11'd1) begin
              slots_d[i].valid = 1'b0;
              miss_d           = miss_d + CNT_W'(1);
            end else begin
              slots_d[i].life = slots_q[i].life - 11'd1;
            end
          end
        end
      end

      // Occupancy is judged on the registered mask and valid bits, so an
      // index being hit is still "lit" and a slot freed this cycle is not
      // yet free.
      spawn_ok = spawn_req && (int'(rand_idx) < NUM_LEDS) &&
                 !(|(led_mask & onehot(rand_idx)));
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        if (spawn_ok && !placed && !slots_q[i].valid) begin
          slots_d[i].valid = 1'b1;
          slots_d[i].idx   = rand_idx;
          slots_d[i].life  = LIFE_MS[level];
          placed           = 1'b1;
        end
      end

      if (game_end) begin
        // Moles still up when time runs out vanish without counting as misses.
        state_d = GAME_OVER;
        time_d  = '0;
        slots_d = '0;
        miss_d  = '0;
      end else if (tick) begin
        time_d = time_left_ms - 15'd1;
      end
    end

    for (int i = 0; i < MAX_ACTIVE; i++) begin
      if (slots_d[i].valid) led_d = led_d | onehot(slots_d[i].idx);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      slots_q      <= '0;
      sw_prev_q    <= '0;
      led_mask     <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      wrong_press  <= 1'b0;
      game_active  <= 1'b0;
      game_over    <= 1'b0;
      time_left_ms <= '0;
    end else begin
      state_q      <= state_d;
      slots_q      <= slots_d;
      sw_prev_q    <= sw_pressed;
      led_mask     <= led_d;
      hit_count    <= hit_d;
      miss_count   <= miss_d;
      wrong_press  <= wrong_d;
      game_active  <= (state_d == PLAYING);
      game_over    <= (state_d == GAME_OVER);
      time_left_ms <= time_d;
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the game rules.
module tb_mole_scheduler;
  import whack_pkg::*;

  localparam int NL = 18;
  localparam int MA = 4;
  localparam int TC = 10;
  localparam int GM = 2000;
  localparam int CW = $clog2(MA + 1);
  localparam int W  = NL + 2 * CW + 3 + 15 + 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n, start, spawn_req;
  logic [1:0]    level;
  logic [4:0]    rand_idx;
  logic [NL-1:0] sw_pressed;
  logic [NL-1:0] led_mask;
  logic [CW-1:0] hit_count, miss_count;
  logic          wrong_press, game_active, game_over;
  logic [14:0]   time_left_ms;
  game_state_t   state_dbg;

  always #5 clk = ~clk;

  mole_scheduler #(
    .NUM_LEDS(NL), .MAX_ACTIVE(MA), .TICK_CYCLES(TC), .GAME_MS(GM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .level(level),
    .spawn_req(spawn_req), .rand_idx(rand_idx), .sw_pressed(sw_pressed),
    .led_mask(led_mask), .hit_count(hit_count), .miss_count(miss_count),
    .wrong_press(wrong_press), .game_active(game_active), .game_over(game_over),
    .time_left_ms(time_left_ms), .state_dbg(state_dbg)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int            life_tbl [4] = '{1500, 1000, 700, 450};
  int            m_pre, m_time;
  bit            m_playing, m_over;
  bit            m_valid [MA];
  int            m_idx   [MA];
  int            m_life  [MA];
  logic [NL-1:0] m_sw_prev;

  function automatic logic [NL-1:0] m_lit();
    logic [NL-1:0] l = '0;
    for (int s = 0; s < MA; s++) if (m_valid[s]) l[m_idx[s]] = 1'b1;
    return l;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_time = 0; m_playing = 0; m_over = 0; m_sw_prev = '0;
    for (int s = 0; s < MA; s++) begin m_valid[s] = 0; m_idx[s] = 0; m_life[s] = 0; end
    exp_q.delete();
  endtask

  // Applies the current inputs to the model for one clock and queues the
  // outputs the DUT should show after that clock.
  task automatic model_step();
    logic [NL-1:0] edges, lit;
    bit            tick, ending, wrong;
    bit            old_valid [MA];
    int            hits, misses, free;
    game_state_t   es;
    edges = sw_pressed & ~m_sw_prev;
    m_sw_prev = sw_pressed;
    hits = 0; misses = 0; wrong = 0;
    if (start) begin
      m_pre = 0; m_time = GM; m_playing = 1; m_over = 0;
      for (int s = 0; s < MA; s++) m_valid[s] = 0;
    end else begin
      tick  = (m_pre == TC - 1);
      m_pre = tick ? 0 : m_pre + 1;
      if (m_playing) begin
        lit       = m_lit();
        old_valid = m_valid;
        wrong     = ((edges & ~lit) != '0);
        ending    = tick && (m_time == 1);
        for (int s = 0; s < MA; s++)
          if (m_valid[s] && edges[m_idx[s]]) begin m_valid[s] = 0; hits++; end
        if (tick)
          for (int s = 0; s < MA; s++)
            if (m_valid[s]) begin
              if (m_life[s] == 1) begin m_valid[s] = 0; misses++; end
              else m_life[s]--;
            end
        free = -1;
        for (int s = MA - 1; s >= 0; s--) if (!old_valid[s]) free = s;
        if (spawn_req && rand_idx < NL && free >= 0) begin
          if (!lit[rand_idx]) begin
            m_valid[free] = 1; m_idx[free] = rand_idx; m_life[free] = life_tbl[level];
          end
        end
        if (ending) begin
          for (int s = 0; s < MA; s++) m_valid[s] = 0;
          misses = 0; m_time = 0; m_playing = 0; m_over = 1;
        end else if (tick) begin
          m_time--;
        end
      end
    end
    es = m_over ? GAME_OVER : (m_playing ? PLAYING : IDLE);
    exp_q.push_back({m_lit(), CW'(hits), CW'(misses), wrong, m_playing, m_over,
                     15'(m_time), 2'(es)});
  endtask

  task automatic compare_outputs();
    logic [W-1:0]  e;
    logic [NL-1:0] e_led;
    logic [CW-1:0] e_hit, e_miss;
    logic          e_wrong, e_act, e_over;
    logic [14:0]   e_time;
    logic [1:0]    e_state;
    e = exp_q.pop_front();
    {e_led, e_hit, e_miss, e_wrong, e_act, e_over, e_time, e_state} = e;
    check("led_mask",     led_mask,     e_led);
    check("hit_count",    hit_count,    e_hit);
    check("miss_count",   miss_count,   e_miss);
    check("wrong_press",  wrong_press,  e_wrong);
    check("game_active",  game_active,  e_act);
    check("game_over",    game_over,    e_over);
    check("time_left_ms", time_left_ms, e_time);
    check("state_dbg",    state_dbg,    e_state);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    start     = 1'b0;
    spawn_req = 1'b0;
  endtask

  task automatic spawn(input int idx);
    spawn_req = 1'b1;
    rand_idx  = 5'(idx);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},    led_mask,     0);
    check({tag, "_hit"},    hit_count,    0);
    check({tag, "_miss"},   miss_count,   0);
    check({tag, "_wrong"},  wrong_press,  0);
    check({tag, "_active"}, game_active,  0);
    check({tag, "_over"},   game_over,    0);
    check({tag, "_time"},   time_left_ms, 0);
    check({tag, "_state"},  state_dbg,    IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  miss_at;
    bit  found;
    int  b;

    reset_n = 1'b0; start = 1'b0; spawn_req = 1'b0; level = 2'd0;
    rand_idx = '0; sw_pressed = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // IDLE ignores spawns and switches.
    sw_pressed[2] = 1'b1;
    spawn(5);
    check("idle_spawn_led", led_mask, 0);
    sw_pressed = '0;
    step();

    // Full round with no moles runs down to GAME_OVER.
    start = 1'b1; step();
    check("start_time", time_left_ms, GM);
    check("start_active", game_active, 1);
    repeat (GM * TC - 1) step();
    check("pre_end_over", game_over, 0);
    step();
    check("end_over", game_over, 1);
    check("end_time", time_left_ms, 0);
    check("end_led", led_mask, 0);
    spawn(3);
    check("over_spawn_led", led_mask, 0);

    // Level 0 mole expires after exactly 1500 ticks.
    start = 1'b1; step();
    level = 2'd0;
    spawn(5);
    check("spawn5_led", led_mask, 18'h00020);
    level = 2'd3;
    miss_at = -1;
    for (int k = 2; k <= 15010 && miss_at < 0; k++) begin
      step();
      if (miss_count == CW'(1)) miss_at = k;
    end
    check("miss_step", miss_at, 15000);
    check("miss_led", led_mask, 0);

    // Spawn rejection: out of range, table full, already lit.
    start = 1'b1; step();
    spawn(20);
    check("range_reject_led", led_mask, 0);
    for (int i = 0; i < 4; i++) begin
      level = 2'($urandom_range(0, 3));
      spawn(i);
    end
    check("fill_led", led_mask, 18'h0000F);
    spawn(4);
    check("full_reject_led", led_mask, 18'h0000F);
    spawn(2);
    check("dup_reject_led", led_mask, 18'h0000F);

    // Double hit, wrong press, held switches.
    start = 1'b1; step();
    spawn(3);
    spawn(7);
    sw_pressed[3] = 1'b1; sw_pressed[7] = 1'b1;
    step();
    check("double_hit", hit_count, 2);
    check("double_hit_led", led_mask, 0);
    step();
    check("held_no_hit", hit_count, 0);
    sw_pressed[9] = 1'b1;
    step();
    check("wrong_press", wrong_press, 1);
    step();
    check("wrong_held", wrong_press, 0);
    sw_pressed = '0;
    step();

    // Hit on the very tick the mole would expire.
    start = 1'b1; step();
    level = 2'd3;
    spawn(6);
    found = 0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (m_valid[0] && m_life[0] == 1 && m_pre == TC - 1) found = 1;
      else step();
    end
    check("life1_reached", found, 1);
    sw_pressed[6] = 1'b1;
    step();
    check("expiry_hit", hit_count, 1);
    check("expiry_miss", miss_count, 0);
    sw_pressed = '0;
    step();

    // Restart mid-round, then asynchronous reset mid-round.
    start = 1'b1; step();
    spawn(1);
    spawn(12);
    repeat (50) step();
    check("two_moles_led", led_mask, 18'h01002);
    start = 1'b1; step();
    check("restart_led", led_mask, 0);
    check("restart_hit", hit_count, 0);
    check("restart_miss", miss_count, 0);
    check("restart_time", time_left_ms, GM);
    spawn(4);
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    #2 reset_n = 1'b1;

    // Randomized play.
    start = 1'b1; step();
    for (int c = 0; c < 25000; c++) begin
      spawn_req = ($urandom_range(0, 39) == 0);
      rand_idx  = 5'($urandom_range(0, 31));
      level     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        b = $urandom_range(0, NL - 1);
        sw_pressed[b] = ~sw_pressed[b];
      end
      start = ($urandom_range(0, 19999) == 0) || (m_over && $urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
